// File: rtl/rv_out_port_pkg.sv
// Shared definitions for the rv_out_port slice.
//   - op_e    : write-port operation encodings (write / set / clear / toggle)
//   - chan_w  : width of a channel index, never less than one bit
package rv_out_port_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLR   = 2'b10,
    OP_TGL   = 2'b11
  } op_e;

  // A single channel still needs a one-bit index field on the bus.
  function automatic int chan_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/rv_out_port_if.sv
// Bus bundle between the CPU store path / event consumer and rv_out_port.
//   write side : wr_valid, wr_ready, wr_chan, wr_op, wr_data
//   pins       : out (channel n at [n*WIDTH +: WIDTH])
//   event side : evt_valid, evt_ready, evt_chan, evt_value, evt_time
//   status     : evt_overflow (sticky), ovf_clear
// master = CPU/consumer side, slave = the output port itself.
interface rv_out_port_if
  import rv_out_port_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2,
  parameter int TS_WIDTH = 16
);
  localparam int CW = chan_w(CHANNELS);

  logic                      wr_valid;
  logic                      wr_ready;
  logic [CW-1:0]             wr_chan;
  logic [1:0]                wr_op;
  logic [WIDTH-1:0]          wr_data;
  logic [CHANNELS*WIDTH-1:0] out;
  logic                      evt_valid;
  logic                      evt_ready;
  logic [CW-1:0]             evt_chan;
  logic [WIDTH-1:0]          evt_value;
  logic [TS_WIDTH-1:0]       evt_time;
  logic                      evt_overflow;
  logic                      ovf_clear;

  modport master (
    output wr_valid, wr_chan, wr_op, wr_data, evt_ready, ovf_clear,
    input  wr_ready, out, evt_valid, evt_chan, evt_value, evt_time, evt_overflow
  );

  modport slave (
    input  wr_valid, wr_chan, wr_op, wr_data, evt_ready, ovf_clear,
    output wr_ready, out, evt_valid, evt_chan, evt_value, evt_time, evt_overflow
  );

endinterface

// File: rtl/rv_out_fifo.sv
// Generic first-word-fall-through FIFO.
//   clk, reset : clock, asynchronous active-low reset
//   push/push_data : write side; pushes while full are dropped
//   pop            : consumer pop; ignored while empty
//   full, valid    : occupancy flags, both decoded from the count register
//   head           : head entry, forced to zero while empty
// DEPTH must be a power of two (pointers wrap naturally), at least 2.
module rv_out_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          valid,
  output logic [DW-1:0] head
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            do_push, do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign valid   = (count != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  // Stale storage never leaks out: an empty FIFO presents zeros.
  assign head    = valid ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; the count register alone defines which
  // entries are live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rv_out_port.sv
// Multi-channel output port with timestamped change log.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : rv_out_port_if.slave (write port, channel pins, event FIFO)
// A write (write/set/clear/toggle) that changes a channel updates it one
// cycle later and logs {chan, new value, timestamp}. Writes to a channel
// index >= CHANNELS are accepted but only raise the sticky overflow flag.
// Build option RV_OUT_PORT_CLK_GATE_EN: each channel register is clocked
// through a clk_gate cell enabled only on a changing write; otherwise plain
// enable flops are used. Port-level cycle behaviour is the same either way.
module rv_out_port
  import rv_out_port_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_WIDTH   = 16
) (
  input logic          clk,
  input logic          reset,
  rv_out_port_if.slave bus
);
  localparam int CW = chan_w(CHANNELS);

  typedef struct packed {
    logic [CW-1:0]       chan;
    logic [WIDTH-1:0]    value;
    logic [TS_WIDTH-1:0] ts;
  } evt_t;

  op_e                 op;
  logic                fifo_full, fifo_valid;
  logic                accept, in_range, changed;
  logic [WIDTH-1:0]    old_val, new_val;
  logic [WIDTH-1:0]    chan_val [CHANNELS];
  logic [CHANNELS-1:0] chan_en;
  logic [TS_WIDTH-1:0] ts_q;
  logic                ovf_q;
  evt_t                push_evt, head_evt;

  assign op          = op_e'(bus.wr_op);
  // Ready depends only on the registered FIFO count, never on evt_ready.
  assign bus.wr_ready = !fifo_full;
  assign accept      = bus.wr_valid && !fifo_full;
  assign in_range    = int'(bus.wr_chan) < CHANNELS;

  // NOTE: every always_comb output gets a value before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    old_val = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (int'(bus.wr_chan) == n) old_val = chan_val[n];
    end
    new_val = bus.wr_data;
    case (op)
      OP_WRITE: new_val = bus.wr_data;
      OP_SET:   new_val = old_val | bus.wr_data;
      OP_CLR:   new_val = old_val & ~bus.wr_data;
      OP_TGL:   new_val = old_val ^ bus.wr_data;
    endcase
  end

  // Value-preserving writes touch nothing, so they neither clock a channel
  // nor consume a FIFO slot.
  assign changed = accept && in_range && (new_val != old_val);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    logic [WIDTH-1:0] q;

    assign chan_en[n] = changed && (int'(bus.wr_chan) == n);

`ifdef RV_OUT_PORT_CLK_GATE_EN
    logic gclk;

    clk_gate u_clk_gate (
      .clk  (clk),
      .en   (chan_en[n]),
      .gclk (gclk)
    );

    always_ff @(posedge gclk or negedge reset) begin
      if (!reset) q <= '0;
      else        q <= new_val;
    end
`else
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)          q <= '0;
      else if (chan_en[n]) q <= new_val;
    end
`endif

    assign chan_val[n]                   = q;
    assign bus.out[n*WIDTH +: WIDTH]     = q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      ts_q <= ts_q + 1'b1;
      // A new overflow in the same cycle as ovf_clear keeps the flag set.
      if (accept && !in_range) ovf_q <= 1'b1;
      else if (bus.ovf_clear)  ovf_q <= 1'b0;
    end
  end

  assign push_evt = {bus.wr_chan, new_val, ts_q};

  rv_out_fifo #(
    .DW    ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (changed),
    .push_data (push_evt),
    .pop       (bus.evt_ready),
    .full      (fifo_full),
    .valid     (fifo_valid),
    .head      (head_evt)
  );

  assign bus.evt_valid    = fifo_valid;
  assign bus.evt_chan     = head_evt.chan;
  assign bus.evt_value    = head_evt.value;
  assign bus.evt_time     = head_evt.ts;
  assign bus.evt_overflow = ovf_q;

endmodule

// File: tb/tb_rv_out_port.sv
// Directed bench for rv_out_port: 3 channels of 10 bits, 4-entry event FIFO,
// 4-bit timestamp. Inputs change and outputs are sampled on the falling
// edge; after the k-th rising edge following reset release the event
// timestamp of a write accepted on that edge is (k-1) mod 16.
module tb_rv_out_port;
  import rv_out_port_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rv_out_port_if #(.WIDTH(10), .CHANNELS(3), .TS_WIDTH(4)) bus ();

  rv_out_port #(
    .WIDTH      (10),
    .CHANNELS   (3),
    .FIFO_DEPTH (4),
    .TS_WIDTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One write presented for exactly one rising edge.
  task automatic wr(input logic [1:0] ch, input logic [1:0] op, input logic [9:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_chan  = ch;
    bus.wr_op    = op;
    bus.wr_data  = d;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  // Check the FIFO head, then pop it on the next rising edge.
  task automatic pop_check(input string tag, input logic [1:0] ch, input logic [9:0] v,
                           input logic [3:0] t);
    check({tag, " valid"}, bus.evt_valid, 1'b1);
    check({tag, " chan"},  bus.evt_chan, ch);
    check({tag, " value"}, bus.evt_value, v);
    check({tag, " time"},  bus.evt_time, t);
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_chan   = '0;
    bus.wr_op     = 2'b00;
    bus.wr_data   = '0;
    bus.evt_ready = 1'b0;
    bus.ovf_clear = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst out",      bus.out, 30'h0);
    check("rst wr_ready", bus.wr_ready, 1'b1);
    check("rst evt_valid", bus.evt_valid, 1'b0);
    check("rst evt_chan", bus.evt_chan, 2'd0);
    check("rst evt_value", bus.evt_value, 10'h0);
    check("rst evt_time", bus.evt_time, 4'h0);
    check("rst ovf",      bus.evt_overflow, 1'b0);

    // First write after release: edge 1, ts 0
    reset = 1'b1;
    wr(2'd0, OP_WRITE, 10'h2A5);
    check("ch0 write", bus.out[9:0], 10'h2A5);
    pop_check("ev ch0", 2'd0, 10'h2A5, 4'd0);               // edge 2
    check("empty after pop", bus.evt_valid, 1'b0);

    // Channel 1 op sequence: edges 3..6, ts 2..5
    wr(2'd1, OP_WRITE, 10'h0F0);
    check("ch1 write", bus.out[19:10], 10'h0F0);
    wr(2'd1, OP_SET, 10'h00F);
    check("ch1 set", bus.out[19:10], 10'h0FF);
    wr(2'd1, OP_CLR, 10'h0C0);
    check("ch1 clear", bus.out[19:10], 10'h03F);
    wr(2'd1, OP_TGL, 10'h3FF);
    check("ch1 toggle", bus.out[19:10], 10'h3C0);
    check("full ready", bus.wr_ready, 1'b0);

    // Fifth write stalls while full (edge 7)
    bus.wr_valid = 1'b1;
    bus.wr_chan  = 2'd2;
    bus.wr_op    = OP_WRITE;
    bus.wr_data  = 10'h155;
    @(negedge clk);
    check("stall ready", bus.wr_ready, 1'b0);
    check("stall ch2", bus.out[29:20], 10'h000);
    check("head ev1 chan", bus.evt_chan, 2'd1);
    check("head ev1 value", bus.evt_value, 10'h0F0);
    check("head ev1 time", bus.evt_time, 4'd2);
    // Pop one (edge 8): ready returns the following cycle
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
    check("ready after pop", bus.wr_ready, 1'b1);
    check("ch2 still held", bus.out[29:20], 10'h000);
    // Stalled write now accepted (edge 9, ts 8)
    @(negedge clk);
    bus.wr_valid = 1'b0;
    check("ch2 accepted", bus.out[29:20], 10'h155);
    check("refull ready", bus.wr_ready, 1'b0);

    // Drain: edges 10..13
    pop_check("ev ch1 set", 2'd1, 10'h0FF, 4'd3);
    pop_check("ev ch1 clr", 2'd1, 10'h03F, 4'd4);
    pop_check("ev ch1 tgl", 2'd1, 10'h3C0, 4'd5);
    pop_check("ev ch2", 2'd2, 10'h155, 4'd8);
    check("drained", bus.evt_valid, 1'b0);

    // Unchanged writes push nothing: edges 14 (ts 13), 15, 16
    wr(2'd0, OP_WRITE, 10'h1C3);
    wr(2'd0, OP_WRITE, 10'h1C3);
    wr(2'd1, OP_SET, 10'h0C0);
    check("same ch0", bus.out[9:0], 10'h1C3);
    check("same ch1", bus.out[19:10], 10'h3C0);
    pop_check("ev same", 2'd0, 10'h1C3, 4'd13);            // edge 17
    check("only one event", bus.evt_valid, 1'b0);

    // Out-of-range channel
    wr(2'd3, OP_WRITE, 10'h3FF);
    check("oor out", bus.out, {10'h155, 10'h3C0, 10'h1C3});
    check("oor no event", bus.evt_valid, 1'b0);
    check("oor ovf set", bus.evt_overflow, 1'b1);
    check("oor ready", bus.wr_ready, 1'b1);
    bus.ovf_clear = 1'b1;
    wr(2'd3, OP_TGL, 10'h3FF);
    bus.ovf_clear = 1'b0;
    check("set beats clear", bus.evt_overflow, 1'b1);
    bus.ovf_clear = 1'b1;
    @(negedge clk);
    bus.ovf_clear = 1'b0;
    check("ovf cleared", bus.evt_overflow, 1'b0);

    // Queue two events, then assert reset between clock edges
    wr(2'd0, OP_TGL, 10'h001);
    wr(2'd2, OP_CLR, 10'h155);
    check("queued ch0", bus.out[9:0], 10'h1C2);
    check("queued ch2", bus.out[29:20], 10'h000);
    check("queued valid", bus.evt_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async out", bus.out, 30'h0);
    check("async evt_valid", bus.evt_valid, 1'b0);
    check("async evt_time", bus.evt_time, 4'h0);
    check("async ready", bus.wr_ready, 1'b1);
    check("async ovf", bus.evt_overflow, 1'b0);
    @(negedge clk);
    @(negedge clk);

    // Timestamp wrap: release, idle 15 edges, write on edges 16 (ts 15) and 17 (ts 0)
    reset = 1'b1;
    repeat (15) @(negedge clk);
    wr(2'd0, OP_WRITE, 10'h011);
    wr(2'd0, OP_WRITE, 10'h022);
    check("wrap ch0", bus.out[9:0], 10'h022);
    pop_check("ev ts 15", 2'd0, 10'h011, 4'd15);
    pop_check("ev ts 0", 2'd0, 10'h022, 4'd0);
    check("final empty", bus.evt_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv_out_port.md
Name: rv_out_port

Overview:
- Parametrised multi-channel output port that replaces the fixed 10-bit `out` bus on the RV CPU.
- The CPU core writes channel values over a valid/ready write interface, using one of four modes: write, set, clear or toggle.
- Every value change is logged into an event FIFO with a timestamp. Benches and the debug path drain this FIFO, so they no longer need to `$monitor` raw wires.
- Sits between the CPU store path and the top-level pins.

Parameters:
- WIDTH, 10, bits per output channel.
- CHANNELS, 2, number of output channels; must be at least 1.
- FIFO_DEPTH, 4, event FIFO entries; must be a power of 2 and at least 2.
- TS_WIDTH, 16, width of the free-running timestamp counter.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset. Assertion clears all state immediately; release is synchronous to clk.
- wr_valid  in  1  write request.
- wr_ready  out  1  port can accept a write (FIFO not full).
- wr_chan  in  max(1,$clog2(CHANNELS))  target channel.
- wr_op  in  2  operation: 00 write, 01 set bits, 10 clear bits, 11 toggle bits.
- wr_data  in  WIDTH  operand.
- out  out  CHANNELS*WIDTH  channel registers; channel n occupies bits [n*WIDTH +: WIDTH].
- evt_valid  out  1  FIFO head entry is valid.
- evt_ready  in  1  consumer pops the head entry.
- evt_chan  out  max(1,$clog2(CHANNELS))  channel of the head event.
- evt_value  out  WIDTH  new channel value carried by the head event.
- evt_time  out  TS_WIDTH  timestamp at which the head event was accepted.
- evt_overflow  out  1  sticky flag: an event was lost.
- ovf_clear  in  1  synchronous clear for evt_overflow.

Behaviour:
- Reset values: out=0, wr_ready=1, evt_valid=0, evt_chan/evt_value/evt_time=0, evt_overflow=0, timestamp counter=0, FIFO empty.
- A write is accepted when wr_valid && wr_ready at a rising edge.
- The new channel value is visible on `out` the following cycle (1-cycle latency).
- Operation results:
  - write: new = wr_data.
  - set: new = old | wr_data.
  - clear: new = old & ~wr_data.
  - toggle: new = old ^ wr_data.
- Event generation:
  - An event {chan, new, ts} is pushed only when new != old. Writes that leave the value unchanged update nothing and push nothing.
  - ts is the counter value in the acceptance cycle.
- wr_ready = !fifo_full. It is registered from the FIFO count and has no combinational path from evt_ready.
- Out-of-range channel (wr_chan >= CHANNELS):
  - The write is accepted (ready honoured), but no register is changed and no event is pushed.
  - evt_overflow is set.
- FIFO:
  - First-word fall-through: the head is valid on the evt_* outputs whenever evt_valid=1.
  - A pop occurs on evt_valid && evt_ready.
  - Simultaneous push and pop is allowed at any occupancy below full; the count is unchanged.
  - Pop while empty is ignored.
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; a separate count register distinguishes full from empty.
- Timestamp:
  - Increments every cycle and wraps 2^TS_WIDTH-1 -> 0 with no flag.
- evt_overflow:
  - Set by an out-of-range write.
  - ovf_clear clears it the next cycle. If a set event and ovf_clear occur in the same cycle, set wins.
- Back-to-back writes to the same channel use the most recently committed value as `old`, so there is no hazard.
- Reset asserted mid-operation: all of the above returns to reset values asynchronously, and in-flight events are discarded.

Optional Feature:
- Macro: RV_OUT_PORT_CLK_GATE_EN.
- Defined:
  - Each channel register is clocked through an instance of the existing clk_gate cell.
  - The gate enable is (write accepted to that channel && new != old).
- Undefined:
  - Plain enable flops on clk.
- Cycle behaviour at the ports is identical in both builds. The bench runs both builds and compares.

Decomposition:
- Package rv_out_port_pkg holds:
  - op encodings OP_WRITE/OP_SET/OP_CLR/OP_TGL;
  - localparam helper for channel index width;
  - packed event struct {chan, value, ts}.
- One sub-module: rv_out_fifo, a generic FWFT FIFO parametrised by data width and depth, storing the packed event.

Test Plan:
- Reset released, then write ch0 op=00 data=10'h2A5 -> out[9:0]=10'h2A5 next cycle; one event {0, 2A5, ts} is produced; evt_valid=1.
- Ch1 write 10'h0F0, then set 10'h00F, clear 10'h0C0, toggle 10'h3FF -> ch1 sequence 0F0, 0FF, 03F, 3C0 with four events whose ts values increase by 1.
- Write the same value 10'h2A5 to ch0 twice -> only the first write produces an event; the FIFO count increases by 1.
- Hold evt_ready=0 and perform 4 changing writes -> wr_ready drops after the 4th. A 5th wr_valid stalls; pop one entry -> wr_ready=1 the next cycle and the 5th write is accepted.
- With CHANNELS=3, write wr_chan=3 -> out unchanged, no event, evt_overflow=1. Assert ovf_clear together with another out-of-range write -> flag stays 1; ovf_clear alone -> flag 0.
- Drop reset low asynchronously mid-stream with 2 events queued -> out=0, evt_valid=0 and ts=0 immediately. Force TS_WIDTH=4 and run 20 cycles -> the ts field wraps 15 -> 0.
